prbs31_checker: RTL and testbench
=================================

Name: prbs31_checker

Overview:
- Serial PRBS31 receiver/checker (x^31 + x^28 + 1): the receive end of the team's PRBS31 generator link.
- Self-synchronises to the incoming bit stream, declares lock, then free-runs a local predictor and counts bit errors.
- Sits after the pad/input synchroniser on a ui_in bit; its status and error count drive uo_out for bring-up and BER measurement.

Parameters:
- LOCK_CNT, 64: consecutive correct predictions in HUNT required to declare lock (range 1..255).
- WIN, 32: length of the loss-of-lock window, in valid bits (range 2..255).
- UNLOCK_ERR, 4: errors within one window that force loss of lock (range 1..WIN).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-high.
- din  in  1  received serial bit; sampled only when din_valid=1.
- din_valid  in  1  qualifies din; when 0, no state changes.
- err_clr  in  1  synchronous clear of err_count.
- locked  out  1  1 = checker in LOCKED state.
- err_pulse  out  1  one-cycle pulse per detected error in LOCKED.
- err_count  out  ERR_W  saturating count of LOCKED errors.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high, on port rst_n (asserted = 1).
- Reset values: hist=0, state=SEED, fill/match/window counters=0, locked=0, err_pulse=0, err_count=0.
- hist[30:0] holds past bits; hist[0] is the newest. Prediction is exp = hist[27] ^ hist[30]. On every shift: hist <= {hist[29:0], newbit}.
- All outputs are registered. Each reacts in the cycle after the din_valid=1 sample that caused it.
- If din_valid=0: everything holds, except err_pulse clears and err_clr still acts.
- SEED:
  - Each valid bit shifts din into hist and increments the fill counter.
  - After the 31st valid bit: go to HUNT with match=0.
- HUNT:
  - Compare din to exp, then shift din into hist (self-synchronous).
  - Match and hist != 0: match++. Mismatch: match=0.
  - hist == 0 (all-zero history): the compare counts as a mismatch. This prevents false lock on a stuck-at-0 line.
  - When match reaches LOCK_CNT: go to LOCKED. locked=1 the next cycle, window counter and window error count are zeroed.
  - HUNT errors do not touch err_count or err_pulse.
- LOCKED (flywheel):
  - Shift exp, not din, into hist, so a single flipped input bit yields exactly one error.
  - Mismatch: err_pulse=1 for one cycle, err_count++ (saturating at 2^ERR_W-1, no wrap), window error count++.
  - The window counter counts valid bits. On the WIN-th valid bit the window counter and window error count reset to 0; an error on that same bit counts into the new window.
  - When window errors (including the current bit) reach UNLOCK_ERR: go to HUNT with match=0, locked=0 the next cycle. hist keeps its flywheel contents; hunting resumes from din.
- err_clr: err_count <= 0. If it coincides with a counted error, err_count <= 1. err_clr does not affect state or window counts.
- Reset asserted mid-operation immediately returns all state to reset values, regardless of clk.
- Stream polarity is not auto-detected. An inverted stream never locks, because inverted PRBS31 does not satisfy the recurrence.

Test Plan:
- Lock: feed the generator stream (LFSR seeded 31'd1, output lfsr[30]) with din_valid=1 every cycle → locked rises exactly 1 cycle after the 95th bit (31 fill + 64 matches); err_count=0 and err_pulse never asserts.
- Single error: after lock, invert bit 200 only → err_pulse high for exactly one cycle, err_count=1, locked stays 1. Then assert err_clr → err_count=0.
- Loss of lock: after lock, invert 4 bits within one 32-bit window → locked drops 1 cycle after the 4th error, err_count=4. Then send a clean stream → locked reasserts after 64 further correct bits.
- Stuck line and gaps: drive din=0 forever → locked never asserts. Generator stream with din_valid toggling 1/0 → lock occurs after 95 valid bits, with no count or state change on invalid cycles.
- Saturation and reset: with ERR_W=4, UNLOCK_ERR=8, invert every 8th bit for 200 bits after lock → locked stays 1, err_count sticks at 15. Assert rst_n=1 mid-stream, asynchronously → locked=0 and err_count=0 at once; relock 95 valid bits after release.

Source files
------------

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) serial receiver/checker.
// Fills a 31-bit history from the line, hunts for a self-synchronised
// match run, then free-runs a flywheel predictor and counts bit errors.
// A burst of errors inside one window drops lock and resumes hunting.
module prbs31_checker #(
    parameter int LOCK_CNT   = 64,
    parameter int WIN        = 32,
    parameter int UNLOCK_ERR = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        SEED,
        HUNT,
        LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [30:0]      hist_q, hist_d;
    logic [4:0]       fill_q, fill_d;
    logic [7:0]       match_q, match_d;
    logic [7:0]       win_q, win_d;
    logic [7:0]       winErr_q, winErr_d;
    logic             locked_q, locked_d;
    logic             errPulse_q, errPulse_d;
    logic [ERR_W-1:0] errCount_q, errCount_d;

    logic             predBit;
    logic             miss;
    logic             countErr;
    logic [7:0]       matchInc;
    logic [7:0]       winBase;
    logic [7:0]       winErrNext;

    // The predictor applies the recurrence to the stored history
    assign predBit  = hist_q[27] ^ hist_q[30];
    assign miss     = din ^ predBit;
    assign matchInc = match_q + 8'd1;

    // Next-state logic for the SEED/HUNT/LOCKED machine and all counters
    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        match_d    = match_q;
        win_d      = win_q;
        winErr_d   = winErr_q;
        locked_d   = locked_q;
        errPulse_d = 1'b0;
        errCount_d = errCount_q;
        countErr   = 1'b0;
        winBase    = winErr_q;
        winErrNext = winErr_q;

        if (din_valid) begin
            case (state_q)
                SEED: begin
                    hist_d = {hist_q[29:0], din};
                    fill_d = fill_q + 5'd1;
                    if (fill_q == 5'd30) begin
                        state_d = HUNT;
                        match_d = 8'd0;
                    end
                end

                HUNT: begin
                    hist_d = {hist_q[29:0], din};
                    // An all-zero history would predict zeros forever, so it never counts as a match
                    if (!miss && (hist_q != 31'd0)) begin
                        match_d = matchInc;
                        if (matchInc == 8'(LOCK_CNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            win_d    = 8'd0;
                            winErr_d = 8'd0;
                        end
                    end else begin
                        match_d = 8'd0;
                    end
                end

                LOCKED: begin
                    // Flywheel: the prediction, not the line, feeds the history
                    hist_d = {hist_q[29:0], predBit};
                    if (win_q == 8'(WIN - 1)) begin
                        win_d   = 8'd0;
                        winBase = 8'd0;
                    end else begin
                        win_d   = win_q + 8'd1;
                        winBase = winErr_q;
                    end
                    winErrNext = winBase + {7'd0, miss};
                    winErr_d   = winErrNext;
                    if (miss) begin
                        errPulse_d = 1'b1;
                        countErr   = 1'b1;
                        if (winErrNext == 8'(UNLOCK_ERR)) begin
                            state_d  = HUNT;
                            match_d  = 8'd0;
                            locked_d = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d = SEED;
                end
            endcase
        end

        // A clear that coincides with a counted error keeps that one error
        if (err_clr) begin
            errCount_d = countErr ? ERR_W'(1) : '0;
        end else if (countErr && (errCount_q != {ERR_W{1'b1}})) begin
            errCount_d = errCount_q + ERR_W'(1);
        end
    end

    // State and counter registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= SEED;
            hist_q     <= 31'd0;
            fill_q     <= 5'd0;
            match_q    <= 8'd0;
            win_q      <= 8'd0;
            winErr_q   <= 8'd0;
            locked_q   <= 1'b0;
            errPulse_q <= 1'b0;
            errCount_q <= '0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            match_q    <= match_d;
            win_q      <= win_d;
            winErr_q   <= winErr_d;
            locked_q   <= locked_d;
            errPulse_q <= errPulse_d;
            errCount_q <= errCount_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = errPulse_q;
    assign err_count = errCount_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker: lock, single error, loss of lock,
// stuck line, gapped stream, saturation and asynchronous reset.
module tb_prbs31_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        din = 1'b0;
    logic        dinValid = 1'b0;
    logic        errClr = 1'b0;

    logic        locked;
    logic        errPulse;
    logic [15:0] errCount;
    logic        satLocked;
    logic        satPulse;
    logic [3:0]  satCount;

    int          checks = 0;
    int          errors = 0;
    logic [30:0] gen = 31'd1;
    int          bitIdx = 0;
    bit          pulseSeen = 1'b0;

    prbs31_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (dinValid),
        .err_clr   (errClr),
        .locked    (locked),
        .err_pulse (errPulse),
        .err_count (errCount)
    );

    prbs31_checker #(
        .ERR_W      (4),
        .UNLOCK_ERR (8)
    ) dutSat (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (dinValid),
        .err_clr   (errClr),
        .locked    (satLocked),
        .err_pulse (satPulse),
        .err_count (satCount)
    );

    // Free-running 100 MHz-style clock
    always #5 clk = ~clk;

    // One cycle of generator stream; invalid cycles put a garbage bit on din
    task automatic applyStimulus(input bit inv, input bit valid, input bit clr);
        bit b;
        b = gen[30];
        if (valid) begin
            gen = {gen[29:0], gen[30] ^ gen[27]};
            bitIdx++;
            din = b ^ inv;
        end else begin
            din = ~b;
        end
        dinValid = valid;
        errClr   = clr;
        @(posedge clk);
        #1;
        if (errPulse) pulseSeen = 1'b1;
        dinValid = 1'b0;
        errClr   = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n    = 1'b1;
        dinValid = 1'b0;
        errClr   = 1'b0;
        #2;
        rst_n     = 1'b0;
        gen       = 31'd1;
        bitIdx    = 0;
        pulseSeen = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_locked: got %b want 0", locked);
        end
        checks++;
        if (errPulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_pulse: got %b want 0", errPulse);
        end
        checks++;
        if (errCount !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d want 0", errCount);
        end
    endtask

    task automatic test_lock();
        applyReset();
        repeat (94) applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lock_early: locked=%b after 94 bits want 0", locked);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_at_95: locked=%b want 1", locked);
        end
        checks++;
        if (errCount !== 16'd0 || pulseSeen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lock_clean: count=%0d pulseSeen=%b want 0/0", errCount, pulseSeen);
        end
    endtask

    task automatic test_single_error();
        while (bitIdx < 199) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checks++;
        if (errPulse !== 1'b1 || errCount !== 16'd1) begin
            errors++;
            $display("[TB] FAIL single_err: pulse=%b count=%0d want 1/1", errPulse, errCount);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (errPulse !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_after: pulse=%b locked=%b want 0/1", errPulse, locked);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checks++;
        if (errCount !== 16'd0) begin
            errors++;
            $display("[TB] FAIL err_clr: count=%0d want 0", errCount);
        end
    endtask

    task automatic test_loss_of_lock();
        while (bitIdx < 299) applyStimulus(1'b0, 1'b1, 1'b0);
        while (bitIdx < 314) applyStimulus(bit'((bitIdx + 1) % 5 == 0), 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b1 || errCount !== 16'd3) begin
            errors++;
            $display("[TB] FAIL lol_before: locked=%b count=%0d want 1/3", locked, errCount);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b0 || errCount !== 16'd4) begin
            errors++;
            $display("[TB] FAIL lol_drop: locked=%b count=%0d want 0/4", locked, errCount);
        end
        while (bitIdx < 378) applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL relock_early: locked=%b want 0", locked);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b1 || errCount !== 16'd4) begin
            errors++;
            $display("[TB] FAIL relock: locked=%b count=%0d want 1/4", locked, errCount);
        end
    endtask

    task automatic test_stuck();
        bit sawLock;
        applyReset();
        sawLock = 1'b0;
        din      = 1'b0;
        dinValid = 1'b1;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (locked) sawLock = 1'b1;
        end
        dinValid = 1'b0;
        checks++;
        if (sawLock !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stuck_zero: sawLock=%b want 0", sawLock);
        end
    endtask

    task automatic test_gaps();
        applyReset();
        repeat (94) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL gaps_early: locked=%b want 0", locked);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gaps_lock: locked=%b want 1", locked);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checks++;
        if (errPulse !== 1'b1 || errCount !== 16'd1) begin
            errors++;
            $display("[TB] FAIL gaps_err: pulse=%b count=%0d want 1/1", errPulse, errCount);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checks++;
        if (errPulse !== 1'b0 || errCount !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL gaps_hold: pulse=%b count=%0d locked=%b want 0/1/1", errPulse, errCount, locked);
        end
    endtask

    task automatic test_saturation();
        applyReset();
        repeat (95) applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (satLocked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_lock: locked=%b want 1", satLocked);
        end
        for (int k = 0; k < 200; k++) begin
            applyStimulus(bit'(k % 8 == 7), 1'b1, 1'b0);
            if (k == 63) begin
                checks++;
                if (satCount !== 4'd8) begin
                    errors++;
                    $display("[TB] FAIL sat_mid: count=%0d want 8", satCount);
                end
            end
        end
        checks++;
        if (satLocked !== 1'b1 || satCount !== 4'd15) begin
            errors++;
            $display("[TB] FAIL sat_stick: locked=%b count=%0d want 1/15", satLocked, satCount);
        end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (satLocked !== 1'b0 || satCount !== 4'd0 || locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: satLocked=%b satCount=%0d locked=%b want 0/0/0", satLocked, satCount, locked);
        end
        @(negedge clk);
        rst_n  = 1'b0;
        gen    = 31'd1;
        bitIdx = 0;
        repeat (94) applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (satLocked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_early: locked=%b want 0", satLocked);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (satLocked !== 1'b1 || locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_lock: satLocked=%b locked=%b want 1/1", satLocked, locked);
        end
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        $display("[TB] prbs31_checker directed tests");
        test_reset();
        test_lock();
        test_single_error();
        test_loss_of_lock();
        test_stuck();
        test_gaps();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
